// File: rtl/muldiv_hilo.sv
// Multicycle multiply/divide unit owning the architectural HI/LO pair.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_hilo #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ReadReq,
    input  logic        Flush,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Stall
);

    localparam int unsigned W  = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 6;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_DIV    = 2'd2,
        S_DIVFIX = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, araw_q, araw_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [MUL_LATENCY-1:0][DW-1:0] pipe_q;

    // Operation decode
    logic is_mul, mul_sgn, is_div, div_sgn, is_mthi, is_mtlo;
`ifdef MULDIV_MADD_EN
    logic is_madd, is_msub;
`endif

    always_comb begin
        is_mul  = (Op == OP_MULT) || (Op == OP_MULTU);
        mul_sgn = (Op == OP_MULT);
        is_div  = (Op == OP_DIV) || (Op == OP_DIVU);
        div_sgn = (Op == OP_DIV);
        is_mthi = (Op == OP_MTHI);
        is_mtlo = (Op == OP_MTLO);
`ifdef MULDIV_MADD_EN
        is_madd = (Op == OP_MADD) || (Op == OP_MADDU);
        is_msub = (Op == OP_MSUB) || (Op == OP_MSUBU);
        if (is_madd || is_msub) begin
            is_mul  = 1'b1;
            mul_sgn = (Op == OP_MADD) || (Op == OP_MSUB);
        end
`endif
    end

    // Low 64 bits of the 64x64 product of extended operands equal the 32x32 result
    logic [DW-1:0] a_ext, b_ext, prod, pipe_in;

    always_comb begin
        a_ext = {{W{mul_sgn & A[W-1]}}, A};
        b_ext = {{W{mul_sgn & B[W-1]}}, B};
        prod  = a_ext * b_ext;
`ifdef MULDIV_MADD_EN
        if (is_madd) begin
            pipe_in = {hi_q, lo_q} + prod;
        end else if (is_msub) begin
            pipe_in = {hi_q, lo_q} - prod;
        end else begin
            pipe_in = prod;
        end
`else
        pipe_in = prod;
`endif
    end

    // Product pipeline; the entry captured at the accept edge reaches the tail at E(MUL_LATENCY)
    if (MUL_LATENCY == 1) begin : g_pipe1
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q[0] <= pipe_in;
            end
        end
    end else begin : g_pipen
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= {pipe_q[MUL_LATENCY-2:0], pipe_in};
            end
        end
    end

    logic [W-1:0] a_mag, b_mag;
    logic [W:0]   div_shift, div_trial;
    logic [W-1:0] quo_fix, rem_fix;

    always_comb begin
        a_mag     = (div_sgn && A[W-1]) ? (~A + 32'd1) : A;
        b_mag     = (div_sgn && B[W-1]) ? (~B + 32'd1) : B;
        div_shift = {rem_q, quo_q[W-1]};
        div_trial = div_shift - {1'b0, dvs_q};
        quo_fix   = qneg_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix   = rneg_q ? (~rem_q + 32'd1) : rem_q;
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        araw_d  = araw_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (!Flush) begin
                    if (is_mthi) hi_d = A;
                    if (is_mtlo) lo_d = A;
                    if (is_mul) begin
                        state_d = S_MUL;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                    end
                    if (is_div) begin
                        state_d = S_DIV;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        quo_d   = a_mag;
                        rem_d   = '0;
                        dvs_d   = b_mag;
                        araw_d  = A;
                        qneg_d  = div_sgn & (A[W-1] ^ B[W-1]);
                        rneg_d  = div_sgn & A[W-1];
                        dz_d    = (B == '0);
                    end
                end
            end
            S_MUL: begin
                if (Flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == MUL_LAST) begin
                    {hi_d, lo_d} = pipe_q[MUL_LATENCY-1];
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIV: begin
                if (Flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (!div_trial[W]) begin
                        rem_d = div_trial[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == DIV_LAST) state_d = S_DIVFIX;
                end
            end
            S_DIVFIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!Flush) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = araw_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            araw_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            araw_q  <= araw_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign Busy  = busy_q;
    assign Stall = busy_q & ((Op != OP_NOP) | ReadReq);

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed table, corner sequences, random vs. model.
module tb_muldiv_hilo;

    localparam int unsigned LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  Op;
    logic [31:0] A, B;
    logic        ReadReq, Flush;
    logic [31:0] Hi, Lo;
    logic        Busy, Stall;

    int checks = 0;
    int errors = 0;

    muldiv_hilo #(.MUL_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .Op(Op), .A(A), .B(B),
        .ReadReq(ReadReq), .Flush(Flush),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall)
    );

    always #5 clock = ~clock;

    // Reference model: architectural state plus a countdown to the pending result
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    bit          m_busy;
    int          m_left;
    logic        last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int sa, sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_busy = 0; m_left = 0; m_pend = '0;
    endtask

    task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        if (m_busy) begin
            if (fl) m_busy = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_busy = 0;
                end
            end
        end else if (!fl) begin
            case (op)
                4'd1, 4'd2: begin m_pend = ref_mul(a, b, op == 4'd1); m_busy = 1; m_left = int'(LAT); end
                4'd3, 4'd4: begin m_pend = ref_div(a, b, op == 4'd3); m_busy = 1; m_left = 33; end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
`ifdef MULDIV_MADD_EN
                4'd7, 4'd8: begin
                    m_pend = {m_hi, m_lo} + ref_mul(a, b, op == 4'd7);
                    m_busy = 1; m_left = int'(LAT);
                end
                4'd9, 4'd10: begin
                    m_pend = {m_hi, m_lo} - ref_mul(a, b, op == 4'd9);
                    m_busy = 1; m_left = int'(LAT);
                end
`endif
                default: ;
            endcase
        end
    endtask

    // Called at posedge+1; drives one cycle, checks Stall mid-cycle and state after the edge
    task automatic tick(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rr, input logic fl);
        Op = op; A = a; B = b; ReadReq = rr; Flush = fl;
        @(negedge clock);
        last_stall = Stall;
        chk("stall", 32'(Stall), 32'(m_busy && (op != 4'd0 || rr)));
        model_edge(op, a, b, fl);
        @(posedge clock);
        #1;
        chk("hi", Hi, m_hi);
        chk("lo", Lo, m_lo);
        chk("busy", 32'(Busy), 32'(m_busy));
    endtask

    task automatic drain(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            tick(4'd0, '0, '0, 1'b0, 1'b0);
            n++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    localparam int NV = 12;
    vec_t vec[NV];

    initial begin
        int n;
        vec[0]  = '{4'd5, 32'hAAAA_AAAA, 32'd0,        32'hAAAA_AAAA, 32'h0000_0000, 0};
        vec[1]  = '{4'd6, 32'h5555_5555, 32'd0,        32'hAAAA_AAAA, 32'h5555_5555, 0};
        vec[2]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, int'(LAT)};
        vec[3]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, int'(LAT)};
        vec[4]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vec[5]  = '{4'd4, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 33};
        vec[6]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vec[7]  = '{4'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 33};
        vec[8]  = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
        vec[9]  = '{4'd3, 32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 33};
        vec[10] = '{4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, int'(LAT)};
        vec[11] = '{4'd15, 32'h1111_1111, 32'd5,       32'hC000_0000, 32'h8000_0000, 0};

        reset = 1'b1; Op = '0; A = '0; B = '0; ReadReq = 1'b0; Flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hi", Hi, 32'd0);
        chk("rst_lo", Lo, 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            tick(vec[i].op, vec[i].a, vec[i].b, 1'b0, 1'b0);
            drain(n);
            chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(vec[i].cyc));
            chk($sformatf("vec%0d_hi", i), Hi, vec[i].hi);
            chk($sformatf("vec%0d_lo", i), Lo, vec[i].lo);
        end

        // MTLO issued while a multiply is in flight is held off until Busy falls
        tick(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        tick(4'd6, 32'd5, 32'd0, 1'b0, 1'b0);
        chk("mtlo_stall1", 32'(last_stall), 32'd1);
        tick(4'd6, 32'd5, 32'd0, 1'b0, 1'b0);
        chk("mtlo_stall2", 32'(last_stall), 32'd1);
        chk("mult_done_lo", Lo, 32'hFFFF_FFFA);
        tick(4'd6, 32'd5, 32'd0, 1'b0, 1'b0);
        chk("mtlo_nostall", 32'(last_stall), 32'd0);
        chk("mtlo_lo", Lo, 32'd5);
        chk("mtlo_hi", Hi, 32'hFFFF_FFFF);

        // ReadReq stalls while dividing, not after completion
        tick(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        repeat (8) tick(4'd0, '0, '0, 1'b0, 1'b0);
        tick(4'd0, '0, '0, 1'b1, 1'b0);
        chk("rr_busy_stall", 32'(last_stall), 32'd1);
        drain(n);
        tick(4'd0, '0, '0, 1'b1, 1'b0);
        chk("rr_idle_stall", 32'(last_stall), 32'd0);
        chk("rr_div_lo", Lo, 32'hFFFF_FFFD);

        // Flush aborts a divide and leaves Hi/Lo untouched
        tick(4'd5, 32'hAAAA_AAAA, '0, 1'b0, 1'b0);
        tick(4'd6, 32'h5555_5555, '0, 1'b0, 1'b0);
        tick(4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (3) tick(4'd0, '0, '0, 1'b0, 1'b0);
        tick(4'd0, '0, '0, 1'b0, 1'b1);
        chk("flush_busy", 32'(Busy), 32'd0);
        chk("flush_hi", Hi, 32'hAAAA_AAAA);
        chk("flush_lo", Lo, 32'h5555_5555);
        tick(4'd5, 32'h1234, '0, 1'b0, 1'b1);
        chk("flush_blocks_mthi", Hi, 32'hAAAA_AAAA);

        // Asynchronous reset in the middle of a divide
        tick(4'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (11) tick(4'd0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        chk("midrst_hi", Hi, 32'd0);
        chk("midrst_lo", Lo, 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Accumulate ops (plain NOPs when the feature is absent)
        tick(4'd5, 32'd0, '0, 1'b0, 1'b0);
        tick(4'd6, 32'd5, '0, 1'b0, 1'b0);
        tick(4'd7, 32'd3, 32'd4, 1'b0, 1'b0);
        drain(n);
`ifdef MULDIV_MADD_EN
        chk("madd_cycles", 32'(n), 32'(LAT));
        chk("madd_hi", Hi, 32'd0);
        chk("madd_lo", Lo, 32'h0000_0011);
`else
        chk("madd_cycles", 32'(n), 32'd0);
        chk("madd_lo", Lo, 32'd5);
`endif
        tick(4'd10, 32'd1, 32'h12, 1'b0, 1'b0);
        drain(n);
`ifdef MULDIV_MADD_EN
        chk("msubu_hi", Hi, 32'hFFFF_FFFF);
        chk("msubu_lo", Lo, 32'hFFFF_FFFF);
`else
        chk("msubu_hi", Hi, 32'd0);
        chk("msubu_lo", Lo, 32'd5);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 15) == 0) rb = 32'hFFFF_FFFF;
            tick(rop, ra, rb, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multicycle multiply/divide unit that owns the architectural HI/LO register pair.
- Sits beside the ALU in EX and is directly upstream of it: its Hi/Lo outputs feed the ALU's MFHI/MFLO result path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX and raises a stall request while an operation is in flight.

Parameters:
MUL_LATENCY, 2, cycles from accept edge to Hi/Lo update for multiply ops; legal range 1..4.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
Op  input  4  request this cycle: 0000 NOP, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MADD, 1000 MADDU, 1001 MSUB, 1010 MSUBU; others = NOP
A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
B  input  32  rt operand (divisor / multiplier)
ReadReq  input  1  EX holds MFHI/MFLO this cycle
Flush  input  1  synchronous abort of any in-flight op
Hi  output  32  architectural HI register
Lo  output  32  architectural LO register
Busy  output  1  registered; op in flight
Stall  output  1  combinational: Busy & ((Op != NOP) | ReadReq)

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, state IDLE, counter 0. Reset mid-operation discards the op.
- An op is accepted only when Busy=0 and Flush=0 at the edge (E0). While Busy=1, Op is ignored; the pipeline holds it via Stall and reissues it.
- Flush has priority over Op in the same cycle. Flush while busy: state goes to IDLE and Busy=0 after the next edge; Hi/Lo keep their pre-op values.
- FSM states: IDLE, MUL, DIV, DIVFIX.
- IDLE, on accept:
  - MTHI / MTLO: write Hi / Lo = A at E0; no Busy.
  - MULT / MULTU: go to MUL.
  - DIV / DIVU: go to DIV.
  - NOP: stay in IDLE.
- MUL:
  - Product is 64-bit, signed for MULT and unsigned for MULTU; it is carried through a pipeline of depth MUL_LATENCY.
  - {Hi,Lo} = product written at edge E(MUL_LATENCY); Busy=1 from E0 until that edge, then IDLE.
- DIV:
  - Operands are latched as magnitudes for DIV, raw for DIVU; quotient sign = A[31]^B[31], remainder sign = A[31] (DIV only).
  - 32 restoring iterations at E1..E32, one quotient bit per edge, 6-bit counter.
  - E33 (DIVFIX): apply sign fix, then Lo = quotient, Hi = remainder; go to IDLE.
  - Busy=1 from E0 until E33.
  - Truncation toward zero.
- Boundaries:
  - Divide by zero (B=0, either op): Lo=FFFF_FFFF, Hi=A.
  - DIV 8000_0000 / FFFF_FFFF: Lo=8000_0000, Hi=0.
  - Both cases take the full 33 cycles.
- Hi/Lo change only at completion edges, MTHI/MTLO, or reset. No partial results are ever visible.
- ReadReq with Busy=0: no stall; the ALU reads the current Hi/Lo that cycle.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined:
  - MADD / MADDU: {Hi,Lo} += A*B (signed / unsigned).
  - MSUB / MSUBU: {Hi,Lo} -= A*B (signed / unsigned).
  - The 64-bit accumulate uses the {Hi,Lo} value sampled at E0 and is written at E(MUL_LATENCY), with the same Busy timing as MULT.
  - Wraps modulo 2^64.
- Undefined: encodings 0111..1010 are treated as NOP; no Busy, no Hi/Lo change, no Stall contribution beyond Op != NOP. The accumulate logic is absent.

Test Plan:
1. MULTU A=FFFF_FFFF B=FFFF_FFFF, MUL_LATENCY=2 -> Busy high 2 cycles; Hi=FFFF_FFFE, Lo=0000_0001 after E2.
2. MULT A=FFFF_FFFE B=0000_0003 -> Hi=FFFF_FFFF, Lo=FFFF_FFFA. Back-to-back MTLO A=5 while busy -> Stall=1; MTLO is accepted the cycle after Busy falls.
3. DIV A=FFFF_FFF9 B=2 -> Busy 33 cycles; Lo=FFFF_FFFD, Hi=FFFF_FFFF. ReadReq at cycle 10 -> Stall=1; at cycle 34 -> Stall=0.
4. DIVU A=1234_5678 B=0 -> Lo=FFFF_FFFF, Hi=1234_5678. DIV 8000_0000/FFFF_FFFF -> Lo=8000_0000, Hi=0.
5. Hi/Lo preloaded 0xAAAA_AAAA/0x5555_5555. DIVU 100/7 with Flush at cycle 5 -> Busy=0 next cycle, Hi/Lo unchanged. Separately, assert reset at cycle 12 of a DIV -> Hi=Lo=0, Busy=0 immediately.
6. With MULDIV_MADD_EN: MTHI 0, MTLO 5, MADD 3*4 -> Hi=0, Lo=0000_0011; then MSUBU 1*0x12 -> Hi=FFFF_FFFF, Lo=FFFF_FFFF. Without the macro: the same Op sequence leaves Lo=5.
